// File: rtl/apb_ss_guard_if.sv
// APB bus bundle shared by the upstream (interconnect) and downstream (subsystem) sides of the guard.
interface apb_ss_guard_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  localparam int unsigned SW = DW / 8;

  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  // Requester side: drives the request, receives the response.
  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  // Completer side: receives the request, drives the response.
  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_ss_guard.sv
// Per-port APB guard: replays each upstream transfer to one student subsystem,
// times out hung wait states, fences the subsystem and answers with PSLVERR locally.
module apb_ss_guard #(
  parameter int unsigned APB_AW    = 32,
  parameter int unsigned APB_DW    = 32,
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_ss_guard_if.slave        s_apb,
  apb_ss_guard_if.master       m_apb,
  input  logic                 ss_enable,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 fence_clr,
  output logic                 fenced,
  output logic                 timeout_evt,
  output logic [ERRCNT_W-1:0]  err_cnt
);
  localparam int unsigned APB_SW = APB_DW / 8;

  typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_e;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic              write;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } req_t;

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic                 fenced_q, fenced_d;
  logic                 tmo_evt_q;
  logic [ERRCNT_W-1:0]  err_q, err_d;
  logic                 local_err_c;
  logic                 setup_c, blocked_c, tmo_hit_c, m_active_c;

  req_t                 m_req_q, m_req_d;
  logic                 m_psel_q, m_psel_d, m_penable_q, m_penable_d;
  logic                 s_pready_q, s_pready_d, s_pslverr_q, s_pslverr_d;
  logic [APB_DW-1:0]    s_prdata_q, s_prdata_d;

  // Upstream setup phase detect, admission decision and saturating wait-state timeout.
  always_comb begin
    setup_c   = s_apb.PSEL & ~s_apb.PENABLE;
    blocked_c = ~ss_enable | fenced_q;
    cnt_inc_c = (cnt_q == {TIMEOUT_W{1'b1}}) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    tmo_hit_c = (state_q == M_ACCESS) && !m_apb.PREADY &&
                (timeout_cycles != '0) && (cnt_inc_c == timeout_cycles);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; M_PREADY takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (setup_c) state_d = blocked_c ? RESP : M_SETUP;
      M_SETUP:  state_d = M_ACCESS;
      M_ACCESS: if (m_apb.PREADY || tmo_hit_c) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values, decoded against the next state.
  always_comb begin
    req_d       = req_q;
    cnt_d       = cnt_q;
    fenced_d    = fenced_q;
    err_d       = err_q;
    local_err_c = 1'b0;
    s_prdata_d  = '0;
    s_pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup_c) begin
          req_d.addr  = s_apb.PADDR;
          req_d.write = s_apb.PWRITE;
          req_d.wdata = s_apb.PWDATA;
          req_d.strb  = s_apb.PSTRB;
          if (blocked_c) begin
            s_pslverr_d = 1'b1;
            local_err_c = 1'b1;
          end
        end
      end
      M_SETUP: cnt_d = '0;
      M_ACCESS: begin
        if (m_apb.PREADY) begin
          s_prdata_d  = m_apb.PRDATA;
          s_pslverr_d = m_apb.PSLVERR;
        end else begin
          cnt_d = cnt_inc_c;
          if (tmo_hit_c) begin
            s_pslverr_d = 1'b1;
            local_err_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A timeout in the same cycle as fence_clr leaves the fence set.
    if (fence_clr) fenced_d = 1'b0;
    if (tmo_hit_c) fenced_d = 1'b1;
    if (local_err_c && (err_q != {ERRCNT_W{1'b1}})) err_d = err_q + ERRCNT_W'(1);
    m_active_c  = (state_d == M_SETUP) || (state_d == M_ACCESS);
    m_psel_d    = m_active_c;
    m_penable_d = (state_d == M_ACCESS);
    m_req_d     = m_active_c ? req_d : '0;
    s_pready_d  = (state_d == RESP);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      cnt_q       <= '0;
      fenced_q    <= 1'b0;
      tmo_evt_q   <= 1'b0;
      err_q       <= '0;
      m_req_q     <= '0;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      s_pready_q  <= 1'b0;
      s_pslverr_q <= 1'b0;
      s_prdata_q  <= '0;
    end else begin
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      fenced_q    <= fenced_d;
      tmo_evt_q   <= tmo_hit_c;
      err_q       <= err_d;
      m_req_q     <= m_req_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      s_pready_q  <= s_pready_d;
      s_pslverr_q <= s_pslverr_d;
      s_prdata_q  <= s_prdata_d;
    end
  end

  assign m_apb.PADDR   = m_req_q.addr;
  assign m_apb.PWRITE  = m_req_q.write;
  assign m_apb.PWDATA  = m_req_q.wdata;
  assign m_apb.PSTRB   = m_req_q.strb;
  assign m_apb.PSEL    = m_psel_q;
  assign m_apb.PENABLE = m_penable_q;
  assign s_apb.PREADY  = s_pready_q;
  assign s_apb.PSLVERR = s_pslverr_q;
  assign s_apb.PRDATA  = s_prdata_q;
  assign fenced        = fenced_q;
  assign timeout_evt   = tmo_evt_q;
  assign err_cnt       = err_q;
endmodule

// File: tb/tb_apb_ss_guard.sv
// Directed self-checking bench for apb_ss_guard.
module tb_apb_ss_guard;
  logic clk = 1'b0;
  logic reset;
  logic ss_enable;
  logic [7:0] timeout_cycles;
  logic fence_clr;
  logic fenced, timeout_evt;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  apb_ss_guard_if #(.AW(32), .DW(32)) up ();
  apb_ss_guard_if #(.AW(32), .DW(32)) dn ();

  apb_ss_guard dut (
    .clk(clk), .reset(reset), .s_apb(up), .m_apb(dn),
    .ss_enable(ss_enable), .timeout_cycles(timeout_cycles), .fence_clr(fence_clr),
    .fenced(fenced), .timeout_evt(timeout_evt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Subsystem model: optional tie-high, hang, or N wait states in access.
  bit          tie1 = 1'b0;
  bit          hang = 1'b0;
  int          wait_cfg = 0;
  logic [31:0] prdata_cfg = '0;
  logic        slverr_cfg = 1'b0;
  int          acc_wait = 0;

  always @(posedge clk) begin
    if (dn.PSEL && dn.PENABLE) acc_wait <= acc_wait + 1;
    else                       acc_wait <= 0;
  end
  assign dn.PREADY  = tie1 | (dn.PSEL & dn.PENABLE & ~hang & (acc_wait >= wait_cfg));
  assign dn.PRDATA  = prdata_cfg;
  assign dn.PSLVERR = slverr_cfg;

  // Bus monitor: downstream select cycles, field stability, idle-zero rules, timeout pulses.
  int          msel_total = 0, fchg_total = 0, mzero_viol = 0, tmo_total = 0, sidle_viol = 0;
  logic [68:0] prev_fields = '0;
  logic        prev_sel = 1'b0;
  logic [31:0] last_paddr = '0, last_pwdata = '0;
  logic        last_pwrite = 1'b0;
  logic [3:0]  last_pstrb = '0;

  always @(negedge clk) begin
    if (dn.PSEL === 1'b1) begin
      msel_total++;
      if (prev_sel && ({dn.PADDR, dn.PWRITE, dn.PWDATA, dn.PSTRB} !== prev_fields)) fchg_total++;
      last_paddr  = dn.PADDR;
      last_pwdata = dn.PWDATA;
      last_pwrite = dn.PWRITE;
      last_pstrb  = dn.PSTRB;
    end else if (dn.PENABLE !== 1'b0 || dn.PADDR !== '0 || dn.PWDATA !== '0 ||
                 dn.PWRITE !== 1'b0 || dn.PSTRB !== '0) begin
      mzero_viol++;
    end
    if (timeout_evt === 1'b1) tmo_total++;
    if (up.PREADY !== 1'b1 && (up.PRDATA !== '0 || up.PSLVERR !== 1'b0)) sidle_viol++;
    prev_sel    = (dn.PSEL === 1'b1);
    prev_fields = {dn.PADDR, dn.PWRITE, dn.PWDATA, dn.PSTRB};
  end

  logic [31:0] rd;
  logic        err;
  int          lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One upstream transfer; lat = cycles from setup to the cycle with S_PREADY.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic slverr, output int latency);
    up.PADDR = addr; up.PWRITE = wr; up.PWDATA = wd; up.PSTRB = 4'hF;
    up.PSEL = 1'b1; up.PENABLE = 1'b0;
    tick();
    up.PENABLE = 1'b1;
    latency = 1;
    while (up.PREADY !== 1'b1 && latency < 2000) begin
      tick();
      latency++;
    end
    rdata = up.PRDATA;
    slverr = up.PSLVERR;
    up.PSEL = 1'b0; up.PENABLE = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (up.PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready got %b want 0", up.PREADY); end
    checks++; if (up.PSLVERR !== 1'b0 || up.PRDATA !== '0) begin errors++; $display("FAIL rst_sresp got %b/%h want 0/0", up.PSLVERR, up.PRDATA); end
    checks++; if (dn.PSEL !== 1'b0 || dn.PENABLE !== 1'b0 || dn.PADDR !== '0) begin errors++; $display("FAIL rst_mbus got %b%b/%h want 00/0", dn.PSEL, dn.PENABLE, dn.PADDR); end
    checks++; if (fenced !== 1'b0 || timeout_evt !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_status got %b %b %0d want 0 0 0", fenced, timeout_evt, err_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_write();
    int m0;
    m0 = msel_total;
    tie1 = 1'b1;
    xfer(32'h0105_0010, 1'b1, 32'hA5A5_0001, rd, err, lat);
    tie1 = 1'b0;
    checks++; if (lat !== 3) begin errors++; $display("FAIL zw_latency got %0d want 3", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_slverr got %b want 0", err); end
    checks++; if (msel_total - m0 !== 2) begin errors++; $display("FAIL zw_psel_cycles got %0d want 2", msel_total - m0); end
    checks++; if (last_paddr !== 32'h0105_0010 || last_pwdata !== 32'hA5A5_0001 || last_pwrite !== 1'b1 || last_pstrb !== 4'hF)
      begin errors++; $display("FAIL zw_fields got %h %h %b %h want 01050010 a5a50001 1 f", last_paddr, last_pwdata, last_pwrite, last_pstrb); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL zw_errcnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_wait_read();
    int t0;
    t0 = tmo_total;
    timeout_cycles = 8'd8; wait_cfg = 4; prdata_cfg = 32'h1234_5678;
    xfer(32'h0105_0020, 1'b0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wr_rdata got %h want 12345678", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_slverr got %b want 0", err); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL wr_latency got %0d want 7", lat); end
    checks++; if (tmo_total !== t0) begin errors++; $display("FAIL wr_no_timeout got %0d want %0d", tmo_total, t0); end
  endtask

  task automatic test_limit_edge();
    int t0;
    t0 = tmo_total;
    timeout_cycles = 8'd3; wait_cfg = 2; prdata_cfg = 32'hCAFE_0003;
    xfer(32'h0105_0030, 1'b0, 32'h0, rd, err, lat);
    checks++; if (rd !== 32'hCAFE_0003 || err !== 1'b0) begin errors++; $display("FAIL edge_resp got %h/%b want cafe0003/0", rd, err); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL edge_latency got %0d want 5", lat); end
    checks++; if (tmo_total !== t0 || fenced !== 1'b0) begin errors++; $display("FAIL edge_no_timeout got %0d/%b want %0d/0", tmo_total, fenced, t0); end
  endtask

  task automatic test_no_timeout();
    int t0;
    t0 = tmo_total;
    timeout_cycles = 8'd0; wait_cfg = 1000; prdata_cfg = 32'h0000_1000;
    xfer(32'h0105_0040, 1'b0, 32'h0, rd, err, lat);
    checks++; if (lat !== 1003) begin errors++; $display("FAIL nt_latency got %0d want 1003", lat); end
    checks++; if (tmo_total !== t0 || err !== 1'b0 || rd !== 32'h0000_1000) begin errors++; $display("FAIL nt_resp got %0d %b %h want %0d 0 00001000", tmo_total, err, rd, t0); end
  endtask

  task automatic test_timeout();
    int t0, m0;
    t0 = tmo_total; m0 = msel_total;
    timeout_cycles = 8'd5; hang = 1'b1; prdata_cfg = 32'hDEAD_BEEF;
    xfer(32'h0105_0050, 1'b0, 32'h0, rd, err, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL to_latency got %0d want 7", lat); end
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL to_resp got %b/%h want 1/0", err, rd); end
    checks++; if (tmo_total - t0 !== 1) begin errors++; $display("FAIL to_evt_cycles got %0d want 1", tmo_total - t0); end
    checks++; if (msel_total - m0 !== 6) begin errors++; $display("FAIL to_psel_cycles got %0d want 6", msel_total - m0); end
    checks++; if (fenced !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL to_status got %b/%0d want 1/1", fenced, err_cnt); end
    hang = 1'b0; wait_cfg = 0;
    m0 = msel_total;
    xfer(32'h0105_0054, 1'b1, 32'h1111_2222, rd, err, lat);
    checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL fence_block got %0d/%b want 1/1", lat, err); end
    checks++; if (msel_total !== m0 || err_cnt !== 8'd2) begin errors++; $display("FAIL fence_noforward got %0d/%0d want %0d/2", msel_total, err_cnt, m0); end
  endtask

  task automatic test_fence_clr();
    int m0;
    fence_clr = 1'b1;
    tick();
    fence_clr = 1'b0;
    checks++; if (fenced !== 1'b0) begin errors++; $display("FAIL fc_cleared got %b want 0", fenced); end
    m0 = msel_total;
    xfer(32'h0105_0060, 1'b1, 32'h5A5A_0002, rd, err, lat);
    checks++; if (lat !== 3 || err !== 1'b0) begin errors++; $display("FAIL fc_xfer got %0d/%b want 3/0", lat, err); end
    checks++; if (msel_total - m0 !== 2 || err_cnt !== 8'd2) begin errors++; $display("FAIL fc_forward got %0d/%0d want 2/2", msel_total - m0, err_cnt); end
  endtask

  // Timeout lands in the same cycle as a fence_clr pulse.
  task automatic test_collision();
    timeout_cycles = 8'd2; hang = 1'b1;
    up.PADDR = 32'h0105_0070; up.PWRITE = 1'b0; up.PWDATA = '0; up.PSTRB = 4'hF;
    up.PSEL = 1'b1; up.PENABLE = 1'b0;
    tick();
    up.PENABLE = 1'b1;
    tick();
    tick();
    fence_clr = 1'b1;
    tick();
    fence_clr = 1'b0;
    checks++; if (up.PREADY !== 1'b1 || up.PSLVERR !== 1'b1 || timeout_evt !== 1'b1)
      begin errors++; $display("FAIL col_resp got %b%b%b want 111", up.PREADY, up.PSLVERR, timeout_evt); end
    checks++; if (fenced !== 1'b1 || err_cnt !== 8'd3) begin errors++; $display("FAIL col_fence got %b/%0d want 1/3", fenced, err_cnt); end
    up.PSEL = 1'b0; up.PENABLE = 1'b0; hang = 1'b0;
    tick();
  endtask

  task automatic test_enable_off();
    int m0, bad;
    logic [7:0] e251, e252;
    bad = 0; e251 = '0; e252 = '0;
    m0 = msel_total;
    ss_enable = 1'b0; prdata_cfg = 32'h7777_7777;
    for (int i = 0; i < 300; i++) begin
      xfer(32'h0105_0080 + 32'(i), 1'b1, 32'(i), rd, err, lat);
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) bad++;
      if (i == 250) e251 = err_cnt;
      if (i == 251) e252 = err_cnt;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL dis_resp bad transfers %0d want 0", bad); end
    checks++; if (msel_total !== m0) begin errors++; $display("FAIL dis_noforward got %0d want %0d", msel_total, m0); end
    checks++; if (e251 !== 8'd254 || e252 !== 8'd255) begin errors++; $display("FAIL dis_errcnt_edge got %0d/%0d want 254/255", e251, e252); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL dis_errcnt_sat got %0d want 255", err_cnt); end
    ss_enable = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    fence_clr = 1'b1;
    tick();
    fence_clr = 1'b0;
    timeout_cycles = 8'd0; hang = 1'b1;
    up.PADDR = 32'h0105_0090; up.PWRITE = 1'b1; up.PWDATA = 32'hFEED_0009; up.PSTRB = 4'hF;
    up.PSEL = 1'b1; up.PENABLE = 1'b0;
    tick();
    up.PENABLE = 1'b1;
    tick();
    tick();
    checks++; if (dn.PSEL !== 1'b1 || dn.PENABLE !== 1'b1) begin errors++; $display("FAIL rm_in_access got %b%b want 11", dn.PSEL, dn.PENABLE); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dn.PSEL !== 1'b0 || dn.PENABLE !== 1'b0 || dn.PADDR !== '0 || dn.PWDATA !== '0)
      begin errors++; $display("FAIL rm_mbus got %b%b %h %h want 00 0 0", dn.PSEL, dn.PENABLE, dn.PADDR, dn.PWDATA); end
    checks++; if (up.PREADY !== 1'b0 || fenced !== 1'b0 || err_cnt !== 8'd0 || timeout_evt !== 1'b0)
      begin errors++; $display("FAIL rm_status got %b %b %0d %b want 0 0 0 0", up.PREADY, fenced, err_cnt, timeout_evt); end
    up.PSEL = 1'b0; up.PENABLE = 1'b0; hang = 1'b0; wait_cfg = 0;
    tick();
    reset = 1'b0;
    tick();
    xfer(32'h0105_00A0, 1'b1, 32'h0000_00A0, rd, err, lat);
    checks++; if (lat !== 3 || err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rm_after got %0d/%b/%0d want 3/0/0", lat, err, err_cnt); end
  endtask

  task automatic test_bus_rules();
    checks++; if (fchg_total !== 0) begin errors++; $display("FAIL m_fields_stable changes %0d want 0", fchg_total); end
    checks++; if (mzero_viol !== 0) begin errors++; $display("FAIL m_zero_idle violations %0d want 0", mzero_viol); end
    checks++; if (sidle_viol !== 0) begin errors++; $display("FAIL s_zero_idle violations %0d want 0", sidle_viol); end
  endtask

  initial begin
    reset = 1'b1; ss_enable = 1'b1; timeout_cycles = 8'd8; fence_clr = 1'b0;
    up.PADDR = '0; up.PSEL = 1'b0; up.PENABLE = 1'b0; up.PWRITE = 1'b0;
    up.PWDATA = '0; up.PSTRB = '0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_limit_edge();
    test_no_timeout();
    test_timeout();
    test_fence_clr();
    test_collision();
    test_enable_off();
    test_reset_mid_access();
    test_bus_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
